// File: rtl/neopixel_pkg.sv
// Shared constants, state encodings and the byte-strobe merge helper for the
// neopixel AXI4-Lite register slave.
package neopixel_pkg;

  localparam logic [2:0] REG_CTRL        = 3'd0;
  localparam logic [2:0] REG_PIXEL_COUNT = 3'd1;
  localparam logic [2:0] REG_COLOR       = 3'd2;
  localparam logic [2:0] REG_TIMING      = 3'd3;
  localparam logic [2:0] REG_STATUS      = 3'd4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/neopixel_reg_bank.sv
// Four byte-strobed 32-bit RW registers plus the read-side mux that also
// exposes STATUS (core busy) and returns zero for unused word slots.
module neopixel_reg_bank
  import neopixel_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_idx_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_strb_i,
  input  logic [2:0]  rd_idx_i,
  input  logic        busy_i,
  output logic [31:0] ctrl_o,
  output logic [31:0] pixel_count_o,
  output logic [31:0] color_o,
  output logic [31:0] timing_o,
  output logic [31:0] rd_data_o
);

  logic [3:0][31:0] regs_q;
  logic [3:0][31:0] regs_d;

  // Word slots 4..7 have no storage; writes there are silently dropped.
  always_comb begin
    regs_d = regs_q;
    if (wr_en_i && !wr_idx_i[2]) begin
      regs_d[wr_idx_i[1:0]] = apply_wstrb(regs_q[wr_idx_i[1:0]], wr_data_i, wr_strb_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    case (rd_idx_i)
      REG_CTRL:        rd_data_o = regs_q[0];
      REG_PIXEL_COUNT: rd_data_o = regs_q[1];
      REG_COLOR:       rd_data_o = regs_q[2];
      REG_TIMING:      rd_data_o = regs_q[3];
      REG_STATUS:      rd_data_o = {31'b0, busy_i};
      default:         rd_data_o = '0;
    endcase
  end

  assign ctrl_o        = regs_q[0];
  assign pixel_count_o = regs_q[1];
  assign color_o       = regs_q[2];
  assign timing_o      = regs_q[3];

endmodule

// File: rtl/neopixel_axi_slave.sv
// AXI4-Lite slave for the neopixel core: write and read handshake FSMs around
// the register bank, plus a one-cycle start pulse on a CTRL.bit0 write.
module neopixel_axi_slave
  import neopixel_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     ctrl_o,
  output logic [31:0]                     pixel_count_o,
  output logic [31:0]                     color_o,
  output logic [31:0]                     timing_o,
  input  logic                            busy_i,
  output logic                            start_o,
  output logic                            dbg_wr_state_o,
  output logic                            dbg_rd_state_o
);

  // Handshake contract: a beat transfers on the rising edge where VALID and
  // READY are both high; AWREADY/WREADY and ARREADY are registered one-cycle
  // pulses, BVALID/RVALID hold (with stable payload) until their READY.

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        start_q, start_d;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [2:0]  rd_idx;
  logic [31:0] bank_rd_data;
  logic        unused_inputs;

  assign wr_idx = S_AXI_AWADDR[4:2];
  assign rd_idx = S_AXI_ARADDR[4:2];
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = 1'b0;
    bvalid_d   = bvalid_q;
    wr_en      = 1'b0;
    start_d    = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        // AW and W are only ever accepted together, in the awready_q cycle.
        if (awready_q) begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            wr_en      = 1'b1;
            bvalid_d   = 1'b1;
            wr_state_d = W_RESP;
            start_d    = (wr_idx == REG_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
          end
        end else if (S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q) begin
          awready_d = 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      R_IDLE: begin
        // Capturing here makes a same-cycle write invisible to this read.
        if (arready_q) begin
          if (S_AXI_ARVALID) begin
            rdata_d    = bank_rd_data;
            rvalid_d   = 1'b1;
            rd_state_d = R_DATA;
          end
        end else if (S_AXI_ARVALID && !rvalid_q) begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      start_q    <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      start_q    <= start_d;
    end
  end

  neopixel_reg_bank u_reg_bank (
    .clk_i         (ACLK),
    .rst_ni        (ARESETN),
    .wr_en_i       (wr_en),
    .wr_idx_i      (wr_idx),
    .wr_data_i     (S_AXI_WDATA),
    .wr_strb_i     (S_AXI_WSTRB),
    .rd_idx_i      (rd_idx),
    .busy_i        (busy_i),
    .ctrl_o        (ctrl_o),
    .pixel_count_o (pixel_count_o),
    .color_o       (color_o),
    .timing_o      (timing_o),
    .rd_data_o     (bank_rd_data)
  );

  assign S_AXI_AWREADY  = awready_q;
  assign S_AXI_WREADY   = awready_q;
  assign S_AXI_BVALID   = bvalid_q;
  assign S_AXI_BRESP    = RESP_OKAY;
  assign S_AXI_ARREADY  = arready_q;
  assign S_AXI_RVALID   = rvalid_q;
  assign S_AXI_RDATA    = rdata_q;
  assign S_AXI_RRESP    = RESP_OKAY;
  assign start_o        = start_q;
  assign dbg_wr_state_o = wr_state_q;
  assign dbg_rd_state_o = rd_state_q;

endmodule

// File: tb/tb_neopixel_axi_slave.sv
// Directed bench for neopixel_axi_slave: register access, strobes, handshake
// timing, start pulse, STATUS/unmapped slots and mid-transaction reset.
module tb_neopixel_axi_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [4:0]  awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [4:0]  araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] ctrl_o, pixel_count_o, color_o, timing_o;
  logic        busy_i = 1'b0;
  logic        start_o;
  logic        dbg_wr_state, dbg_rd_state;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) if (start_o) start_cnt++;

  neopixel_axi_slave dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .S_AXI_AWADDR   (awaddr),
    .S_AXI_AWPROT   (awprot),
    .S_AXI_AWVALID  (awvalid),
    .S_AXI_AWREADY  (awready),
    .S_AXI_WDATA    (wdata),
    .S_AXI_WSTRB    (wstrb),
    .S_AXI_WVALID   (wvalid),
    .S_AXI_WREADY   (wready),
    .S_AXI_BRESP    (bresp),
    .S_AXI_BVALID   (bvalid),
    .S_AXI_BREADY   (bready),
    .S_AXI_ARADDR   (araddr),
    .S_AXI_ARPROT   (arprot),
    .S_AXI_ARVALID  (arvalid),
    .S_AXI_ARREADY  (arready),
    .S_AXI_RDATA    (rdata),
    .S_AXI_RRESP    (rresp),
    .S_AXI_RVALID   (rvalid),
    .S_AXI_RREADY   (rready),
    .ctrl_o         (ctrl_o),
    .pixel_count_o  (pixel_count_o),
    .color_o        (color_o),
    .timing_o       (timing_o),
    .busy_i         (busy_i),
    .start_o        (start_o),
    .dbg_wr_state_o (dbg_wr_state),
    .dbg_rd_state_o (dbg_rd_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks are entered and left 1ns after a rising edge.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit seen;
    seen = 1'b0;
    resp = 2'b11;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge ACLK); #1;
      if (awready && wready) begin seen = 1'b1; break; end
    end
    check_eq("aw_w_handshake", 32'(seen), 32'd1);
    @(posedge ACLK); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin seen = 1'b1; resp = bresp; break; end
      @(posedge ACLK); #1;
    end
    check_eq("b_handshake", 32'(seen), 32'd1);
    @(posedge ACLK); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit seen;
    seen = 1'b0;
    data = '0; resp = 2'b11;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge ACLK); #1;
      if (arready) begin seen = 1'b1; break; end
    end
    check_eq("ar_handshake", 32'(seen), 32'd1);
    @(posedge ACLK); #1;
    arvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) begin seen = 1'b1; data = rdata; resp = rresp; break; end
      @(posedge ACLK); #1;
    end
    check_eq("r_handshake", 32'(seen), 32'd1);
    @(posedge ACLK); #1;
    rready = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [4:0] addr);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    check_eq({tag, "_rresp"}, 32'(r), 32'd0);
    check_eq(tag, d, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  resp;
    logic [1:0]  rresp_c;
    logic [31:0] rd_c;
    int          base;
    int          hs_cnt;
    int          b_cnt;
    bit          seen;

    repeat (3) @(posedge ACLK);
    #1;
    check_eq("rst_awready", 32'(awready), 32'd0);
    check_eq("rst_wready",  32'(wready),  32'd0);
    check_eq("rst_bvalid",  32'(bvalid),  32'd0);
    check_eq("rst_arready", 32'(arready), 32'd0);
    check_eq("rst_rvalid",  32'(rvalid),  32'd0);
    check_eq("rst_rdata",   rdata,        32'd0);
    check_eq("rst_ctrl",    ctrl_o,       32'd0);
    check_eq("rst_timing",  timing_o,     32'd0);
    check_eq("rst_start",   32'(start_o), 32'd0);
    @(negedge ACLK); ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // Basic write / readback of the four RW registers.
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp);
      check_eq("wr_bresp", 32'(resp), 32'd0);
    end
    check_eq("pixel_count_port", pixel_count_o, 32'd2);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'(i + 1));
      read_expect("rd_basic", 5'(i * 4));
    end

    // Byte strobes.
    axi_write(5'h08, 32'h0, 4'hF, resp);
    axi_write(5'h08, 32'hAABBCCDD, 4'b0101, resp);
    check_eq("color_port_strb", color_o, 32'h00BB00DD);
    exp_q.push_back(32'h00BB00DD);
    read_expect("rd_strb", 5'h08);

    // AW three cycles ahead of W, BREADY low for five cycles.
    hs_cnt = 0; b_cnt = 0;
    awaddr = 5'h0C; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge ACLK); #1;
      if (awready || wready) hs_cnt++;
    end
    check_eq("aw_early_no_accept", 32'(hs_cnt), 32'd0);
    wvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge ACLK); #1;
      if (awready && wready) hs_cnt++;
      if (awready != wready) check_eq("aw_w_together", 32'(wready), 32'(awready));
      if (bvalid) begin seen = 1'b1; break; end
    end
    check_eq("late_w_bvalid", 32'(seen), 32'd1);
    awvalid = 1'b0; wvalid = 1'b0;
    b_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge ACLK); #1;
      if (bvalid) b_cnt++;
      if (awready) hs_cnt++;
    end
    check_eq("single_accept", 32'(hs_cnt), 32'd1);
    check_eq("bvalid_held", 32'(b_cnt), 32'd5);
    bready = 1'b1;
    @(posedge ACLK); #1;
    check_eq("bvalid_cleared", 32'(bvalid), 32'd0);
    bready = 1'b0;
    check_eq("timing_port", timing_o, 32'h55);

    // Start pulse.
    base = start_cnt;
    axi_write(5'h00, 32'h1, 4'hF, resp);
    check_eq("start_one_cycle", 32'(start_cnt - base), 32'd1);
    check_eq("ctrl_not_self_clear", ctrl_o, 32'h1);
    base = start_cnt;
    axi_write(5'h00, 32'h0, 4'hF, resp);
    check_eq("start_none_on_zero", 32'(start_cnt - base), 32'd0);
    base = start_cnt;
    axi_write(5'h00, 32'h1, 4'b1110, resp);
    check_eq("start_none_no_strb0", 32'(start_cnt - base), 32'd0);
    base = start_cnt;
    axi_write(5'h04, 32'h1, 4'hF, resp);
    check_eq("start_none_other_reg", 32'(start_cnt - base), 32'd0);

    // STATUS and unmapped slots.
    busy_i = 1'b1;
    exp_q.push_back(32'h1);
    read_expect("rd_status_busy", 5'h10);
    busy_i = 1'b0;
    exp_q.push_back(32'h0);
    read_expect("rd_status_idle", 5'h10);
    axi_write(5'h10, 32'hFFFF, 4'hF, resp);
    check_eq("wr_status_bresp", 32'(resp), 32'd0);
    exp_q.push_back(32'h0);
    read_expect("rd_status_after_wr", 5'h10);
    exp_q.push_back(32'h0);
    read_expect("rd_slot5", 5'h14);
    check_eq("ctrl_unchanged", ctrl_o, 32'h0);
    check_eq("pixcnt_unchanged", pixel_count_o, 32'h1);

    // Same-cycle read and write of one register: read sees the old value.
    fork
      axi_write(5'h04, 32'h1234, 4'hF, resp);
      axi_read(5'h04, rd_c, rresp_c);
    join
    check_eq("rd_during_wr_old", rd_c, 32'h1);
    exp_q.push_back(32'h1234);
    read_expect("rd_after_wr_new", 5'h04);

    // Reset while a write response is pending.
    axi_write(5'h00, 32'h5, 4'hF, resp);
    awaddr = 5'h04; wdata = 32'h99; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge ACLK); #1;
      if (bvalid) begin seen = 1'b1; break; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("pend_bvalid", 32'(seen), 32'd1);
    check_eq("pend_written", pixel_count_o, 32'h99);
    #2;
    ARESETN = 1'b0;
    #1;
    check_eq("mid_rst_bvalid", 32'(bvalid), 32'd0);
    check_eq("mid_rst_ctrl", ctrl_o, 32'h0);
    check_eq("mid_rst_pixcnt", pixel_count_o, 32'h0);
    @(negedge ACLK); ARESETN = 1'b1;
    @(posedge ACLK); #1;
    axi_write(5'h04, 32'h7, 4'hF, resp);
    check_eq("post_rst_bresp", 32'(resp), 32'd0);
    exp_q.push_back(32'h7);
    read_expect("rd_post_rst", 5'h04);

    repeat (2) @(posedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
